// File: rtl/idu_pkg.sv
// Shared IDU types: fetch-queue entry layout
// and the NOP driven on empty issue slots.
package idu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } t_fq_entry;

endpackage

// File: rtl/idu_fetch_queue.sv
// Dual-issue fetch queue: 2-in / 2-out circular
// buffer presenting the two oldest entries to the IDU.
module idu_fetch_queue
  import idu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   Clk,
  input  logic                   RstN,
  input  logic                   flush,
  input  logic [1:0]             in_cnt,
  input  logic [31:0]            in_instr0,
  input  logic [31:0]            in_instr1,
  input  logic [31:0]            in_pc0,
  input  logic [31:0]            in_pc1,
  output logic                   in_ready,
  input  logic [1:0]             issue_cnt,
  output logic                   out_valid1,
  output logic                   out_valid2,
  output logic [31:0]            out_instr1,
  output logic [31:0]            out_instr2,
  output logic [31:0]            out_pc1,
  output logic [31:0]            out_pc2,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  t_fq_entry mem [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] occ;
  logic [1:0]    push_n;
  logic [1:0]    issue_n;
  logic [1:0]    pop_n;
  logic [1:0]    wr_step;
  logic [AW-1:0] rd_idx0;
  logic [AW-1:0] rd_idx1;
  logic [AW-1:0] wr_idx0;
  logic [AW-1:0] wr_idx1;
  t_fq_entry     slot1;
  t_fq_entry     slot2;

  always_comb begin
    push_n  = in_cnt[1] ? 2'd2 : in_cnt;
    issue_n = issue_cnt[1] ? 2'd2 : issue_cnt;
    occ     = wr_ptr - rd_ptr;
    // no credit for the same-cycle pop keeps this off the issue path
    in_ready = (occ <= PW'(DEPTH - 2));
    wr_step  = in_ready ? push_n : 2'd0;
    pop_n    = (occ >= PW'(issue_n)) ? issue_n : occ[1:0];
  end

  always_comb begin
    rd_idx0 = rd_ptr[AW-1:0];
    rd_idx1 = rd_idx0 + AW'(1);
    wr_idx0 = wr_ptr[AW-1:0];
    wr_idx1 = wr_idx0 + AW'(1);
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop_n);
      wr_ptr <= wr_ptr + PW'(wr_step);
    end
  end

  // storage needs no reset; the valids gate stale entries
  always_ff @(posedge Clk) begin
    if (!flush && wr_step != 2'd0) begin
      mem[wr_idx0] <= '{pc: in_pc0, instr: in_instr0};
      if (wr_step == 2'd2) begin
        mem[wr_idx1] <= '{pc: in_pc1, instr: in_instr1};
      end
    end
  end

  always_comb begin
    slot1      = mem[rd_idx0];
    slot2      = mem[rd_idx1];
    count      = occ;
    out_valid1 = (occ != '0);
    out_valid2 = (occ >= PW'(2));
    out_instr1 = out_valid1 ? slot1.instr : NOP_INSTR;
    out_pc1    = out_valid1 ? slot1.pc : 32'h0;
    out_instr2 = out_valid2 ? slot2.instr : NOP_INSTR;
    out_pc2    = out_valid2 ? slot2.pc : 32'h0;
  end

endmodule

// File: doc/idu_fetch_queue.md
# idu_fetch_queue

Instruction fetch queue that feeds the dual-issue IDU. It buffers fetched instructions with their PCs, presents the two oldest entries as the IDU's instr1/instr2 pair, and retires 0, 1 or 2 entries per cycle according to how many the IDU actually issued. It sits between the fetch stage and the IDU, and absorbs dependency stalls (RAW, WAW, branch) without dropping or reordering instructions.

## Interface
- DEPTH, 8, number of entries; power of two, at least 4
- Clk  in  1  clock; all state updates on rising edge
- RstN  in  1  reset, asynchronous, active-low
- flush  in  1  discard all queued entries (mispredict or redirect)
- in_cnt  in  2  instructions pushed this cycle; 0, 1 or 2; 3 is treated as 2
- in_instr0  in  32  older pushed instruction; valid when in_cnt is at least 1
- in_instr1  in  32  younger pushed instruction; valid when in_cnt is 2
- in_pc0  in  32  PC of in_instr0
- in_pc1  in  32  PC of in_instr1
- in_ready  out  1  queue accepts a push this cycle
- issue_cnt  in  2  entries consumed by the IDU this cycle; 0, 1 or 2; 3 is treated as 2
- out_valid1  out  1  out_instr1/out_pc1 hold the oldest entry
- out_valid2  out  1  out_instr2/out_pc2 hold the second-oldest entry
- out_instr1  out  32  to IDU instr1
- out_instr2  out  32  to IDU instr2
- out_pc1  out  32  PC of out_instr1
- out_pc2  out  32  PC of out_instr2
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage is a circular buffer of {pc, instr} entries.
  - rd_ptr and wr_ptr are each $clog2(DEPTH)+1 bits wide; the extra MSB is the wrap bit.
  - count = wr_ptr - rd_ptr (modular).
- Output slots:
  - Slot 1 = entry at rd_ptr. out_valid1 = (count >= 1).
  - Slot 2 = entry at rd_ptr+1, taken modulo DEPTH. out_valid2 = (count >= 2).
  - out_valid2 never asserts without out_valid1.
  - An invalid slot drives NOP 32'h00000013 (addi x0,x0,0) on instr and 32'h0 on pc.
- in_ready = (count <= DEPTH-2), computed from current occupancy only. The same-cycle pop is not credited, so a 2-wide push always fits.
- Push:
  - Happens when in_ready=1 and in_cnt>0.
  - in_instr0 is written at wr_ptr, then in_instr1 at wr_ptr+1.
  - wr_ptr advances by the effective in_cnt.
  - A push while in_ready=0 is ignored; the source must hold it.
- Pop:
  - Effective pop = min(issue_cnt, count). Over-issue clips silently; pointers never pass each other.
  - rd_ptr advances by the effective pop.
- Push and pop in the same cycle are both applied: next count = count + push - pop.
- Flush has priority over push and pop in the same cycle.
  - rd_ptr <= wr_ptr; that cycle's push is dropped.
  - Next cycle: count=0, both valids 0.
- Pointer wrap: indices are taken modulo DEPTH. A pair that straddles the end of the buffer (slot 1 at index DEPTH-1, slot 2 at index 0) is presented correctly.

## Timing
- Reset (asynchronous assert, synchronous release) sets:
  - rd_ptr=wr_ptr=0, count=0, in_ready=1
  - out_valid1=out_valid2=0, out_instr1=out_instr2=32'h00000013, out_pc1=out_pc2=0
- Push-to-visible latency is 1 cycle. An entry written at edge N appears on slot 1 or 2 after edge N; there is no bypass from in_* to out_*.
- Output paths:
  - out_* are combinational from registered storage and pointers.
  - issue_cnt is sampled only at the edge; there is no combinational path from issue_cnt to out_*.
- Reset asserted mid-operation drops all contents immediately. Storage contents need not be cleared because the valids gate them.
- Throughput: 2 in and 2 out per cycle sustained.

## Structure
- Shared package idu_pkg holds:
  - localparam NOP_INSTR = 32'h00000013
  - typedef t_fq_entry = struct packed {logic [31:0] pc; logic [31:0] instr;}
- No sub-module; the storage array, pointer logic and read muxes live in one module.
- The IDU connects out_instr1/2 to its instr1/instr2 inputs. The IDU's issue decision drives issue_cnt.

## Test plan
- Reset then idle: count=0, in_ready=1, valids 0, both out_instr=00000013.
- Push {00200093@pc 0, 00300113@pc 4} with issue_cnt=0:
  - Next cycle: out_valid1=out_valid2=1, out_instr1=00200093, out_instr2=00300113, count=2.
  - Then issue_cnt=2: count=0.
- RAW stall: queue holds 00200093, 00100113, 00300113; issue_cnt=1.
  - Next cycle: out_instr1=00100113, out_instr2=00300113, count=2.
- Fill with DEPTH=8:
  - Push 2 per cycle with issue_cnt=0. in_ready drops once count=7 or 8. A push attempted while in_ready=0 leaves count unchanged.
  - Then issue 2 per cycle while pushing 2: slot order matches push order across the index 7 to 0 wrap.
- Flush while count=5, with simultaneous in_cnt=2 and issue_cnt=2: next cycle count=0, valids 0.
- Over-issue: count=1 with issue_cnt=2 gives count=0, and no pointer corruption on the following push/pop sequence.
